// File: rtl/lp_lock_monitor.sv
// ---------------------------------------------------------------------------
// LpLockMonitor (module lp_lock_monitor)
//
// Purpose:
//    Tracks which logical process (LP) each simulation core is working on.
//    Keeps two cores from running events of the same LP at the same time.
//    A core dispatched an event whose LP is already owned by another active
//    core is stalled. When the owning core finishes, the waiter with the
//    oldest timestamp is released. The block also publishes the smallest
//    timestamp among active cores and a sticky protocol-error flag.
//
// Ports:
//    clk             in   clock
//    reset           in   synchronous active-high reset
//    msg             in   dispatched event (time in low bits, LP id above)
//    sent_msg_vld    in   msg is dispatched to core sent_core_id this cycle
//    sent_core_id    in   destination core
//    rcv_msg_vld     in   core rcv_core_id finished its event this cycle
//    rcv_core_id     in   finishing core
//    stall           out  per-core stall (includes same-cycle send conflict)
//    release_vld     out  one-cycle pulse, a stalled core was released
//    release_core_id out  released core
//    min_time        out  smallest timestamp among active cores (registered)
//    min_time_vld    out  at least one core active (registered)
//    active_cnt      out  number of active cores (registered)
//    proto_err       out  sticky protocol-violation flag
// ---------------------------------------------------------------------------
module lp_lock_monitor #(
   parameter int NUM_CORE = 4,
   parameter int NUM_LP   = 8,
   parameter int TIME_WID = 16,
   parameter int MSG_WID  = 32,
   localparam int NB_LP   = $clog2(NUM_LP),
   localparam int CW      = $clog2(NUM_CORE),
   localparam int AW      = $clog2(NUM_CORE + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [MSG_WID-1:0]  msg,
   input  logic                sent_msg_vld,
   input  logic [CW-1:0]       sent_core_id,
   input  logic                rcv_msg_vld,
   input  logic [CW-1:0]       rcv_core_id,
   output logic [NUM_CORE-1:0] stall,
   output logic                release_vld,
   output logic [CW-1:0]       release_core_id,
   output logic [TIME_WID-1:0] min_time,
   output logic                min_time_vld,
   output logic [AW-1:0]       active_cnt,
   output logic                proto_err
);

   // Per-core table and registered outputs.
   logic [TIME_WID-1:0] evTime_q [NUM_CORE];
   logic [TIME_WID-1:0] evTime_d [NUM_CORE];
   logic [NB_LP-1:0]    lp_q     [NUM_CORE];
   logic [NB_LP-1:0]    lp_d     [NUM_CORE];
   logic [NUM_CORE-1:0] active_q,  active_d;
   logic [NUM_CORE-1:0] stalled_q, stalled_d;
   logic                protoErr_q, protoErr_d;
   logic                relVld_q,   relVld_d;
   logic [CW-1:0]       relId_q,    relId_d;
   logic [TIME_WID-1:0] minTime_q;
   logic                minVld_q;
   logic [AW-1:0]       activeCnt_q, activeCnt_d;

   // Decoded request fields.
   logic [TIME_WID-1:0] msgTime;
   logic [NB_LP-1:0]    msgLp;
   logic                rcvOk;
   logic                rcvBad;
   logic [NUM_CORE-1:0] rcvOh;
   logic [NUM_CORE-1:0] waiters;
   logic                relFound;
   logic [CW-1:0]       relIdx;
   logic [TIME_WID-1:0] relBestTime;
   logic                sendConflict;
   logic                sendBad;
   logic [NUM_CORE-1:0] conflictOh;

   // Only the time and LP fields of msg are meaningful here.
   logic unusedMsg;
   assign unusedMsg = ^msg;

   assign msgTime = msg[TIME_WID-1:0];
   assign msgLp   = msg[TIME_WID +: NB_LP];

   // Receive decode: a finish from an inactive core is a protocol error
   // and must not disturb the table or trigger a release.
   always_comb begin
      rcvOk  = rcv_msg_vld &&  active_q[rcv_core_id];
      rcvBad = rcv_msg_vld && !active_q[rcv_core_id];
      rcvOh  = '0;
      if (rcvOk) begin
         rcvOh[rcv_core_id] = 1'b1;
      end
   end

   // Waiter selection: among stalled cores on the finishing core's LP,
   // pick the smallest timestamp. The strict less-than keeps the lowest
   // core index on ties because cores are scanned in ascending order.
   always_comb begin
      waiters     = '0;
      relFound    = 1'b0;
      relIdx      = '0;
      relBestTime = '0;
      for (int j = 0; j < NUM_CORE; j++) begin
         waiters[j] = rcvOk && active_q[j] && stalled_q[j] && !rcvOh[j] &&
                      (lp_q[j] == lp_q[rcv_core_id]);
         if (waiters[j] && (!relFound || (evTime_q[j] < relBestTime))) begin
            relFound    = 1'b1;
            relIdx      = CW'(j);
            relBestTime = evTime_q[j];
         end
      end
   end

   // Send conflict check is done against the table as it looks after the
   // same-cycle receive: the finishing core no longer owns the LP, but a
   // waiter released by that receive still does.
   always_comb begin
      sendConflict = 1'b0;
      for (int j = 0; j < NUM_CORE; j++) begin
         if (sent_msg_vld && (CW'(j) != sent_core_id) && active_q[j] &&
             !rcvOh[j] && (lp_q[j] == msgLp)) begin
            sendConflict = 1'b1;
         end
      end
      sendBad    = sent_msg_vld && active_q[sent_core_id] && !rcvOh[sent_core_id];
      conflictOh = '0;
      if (sendConflict) begin
         conflictOh[sent_core_id] = 1'b1;
      end
   end

   // Next-state table update: receive first, then send, so a send may
   // overwrite a core that is finishing or being released in this cycle.
   always_comb begin
      evTime_d   = evTime_q;
      lp_d       = lp_q;
      active_d   = active_q;
      stalled_d  = stalled_q;
      protoErr_d = protoErr_q | rcvBad | sendBad;
      relVld_d   = relFound;
      relId_d    = relFound ? relIdx : relId_q;
      if (rcvOk) begin
         active_d[rcv_core_id]  = 1'b0;
         stalled_d[rcv_core_id] = 1'b0;
      end
      if (relFound) begin
         stalled_d[relIdx] = 1'b0;
      end
      if (sent_msg_vld) begin
         evTime_d[sent_core_id]  = msgTime;
         lp_d[sent_core_id]      = msgLp;
         active_d[sent_core_id]  = 1'b1;
         stalled_d[sent_core_id] = sendConflict;
      end
   end

   // Population count of the post-edge active vector.
   always_comb begin
      activeCnt_d = '0;
      for (int i = 0; i < NUM_CORE; i++) begin
         activeCnt_d = activeCnt_d + AW'(active_d[i]);
      end
   end

   // Minimum-time reduction tree over the current table, one level per
   // bit of the core index. Inactive leaves carry time 0 and lose every
   // comparison, so an all-inactive subtree also reports time 0.
   for (genvar l = 0; l <= CW; l++) begin : gLvl
      localparam int N = NUM_CORE >> l;
      logic [TIME_WID-1:0] nodeTime [N];
      logic [N-1:0]        nodeVld;
      for (genvar n = 0; n < N; n++) begin : gNode
         if (l == 0) begin : gLeaf
            assign nodeVld[n]  = active_q[n];
            assign nodeTime[n] = active_q[n] ? evTime_q[n] : '0;
         end else begin : gInner
            logic takeLeft;
            assign takeLeft = gLvl[l-1].nodeVld[2*n] &&
                              (!gLvl[l-1].nodeVld[2*n+1] ||
                               (gLvl[l-1].nodeTime[2*n] <= gLvl[l-1].nodeTime[2*n+1]));
            assign nodeVld[n]  = gLvl[l-1].nodeVld[2*n] | gLvl[l-1].nodeVld[2*n+1];
            assign nodeTime[n] = takeLeft ? gLvl[l-1].nodeTime[2*n]
                                          : gLvl[l-1].nodeTime[2*n+1];
         end
      end
   end

   // State register with synchronous reset; reset drops every waiter
   // without producing release pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CORE; i++) begin
            evTime_q[i] <= '0;
            lp_q[i]     <= '0;
         end
         active_q    <= '0;
         stalled_q   <= '0;
         protoErr_q  <= 1'b0;
         relVld_q    <= 1'b0;
         relId_q     <= '0;
         minTime_q   <= '0;
         minVld_q    <= 1'b0;
         activeCnt_q <= '0;
      end else begin
         evTime_q    <= evTime_d;
         lp_q        <= lp_d;
         active_q    <= active_d;
         stalled_q   <= stalled_d;
         protoErr_q  <= protoErr_d;
         relVld_q    <= relVld_d;
         relId_q     <= relId_d;
         minTime_q   <= gLvl[CW].nodeTime[0];
         minVld_q    <= gLvl[CW].nodeVld[0];
         activeCnt_q <= activeCnt_d;
      end
   end

   // The same-cycle conflict term is suppressed while reset is held.
   assign stall           = stalled_q | (reset ? '0 : conflictOh);
   assign release_vld     = relVld_q;
   assign release_core_id = relId_q;
   assign min_time        = minTime_q;
   assign min_time_vld    = minVld_q;
   assign active_cnt      = activeCnt_q;
   assign proto_err       = protoErr_q;

endmodule

// File: tb/tb_lp_lock_monitor.sv
// ---------------------------------------------------------------------------
// Testbench for lp_lock_monitor. A behavioural model holds the core table
// as plain arrays. Each cycle it applies "finish, then dispatch" and checks
// every output. Directed scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_lp_lock_monitor;

   localparam int NUM_CORE = 4;
   localparam int NUM_LP   = 8;
   localparam int TIME_WID = 16;
   localparam int MSG_WID  = 32;

   logic        clk;
   logic        reset;
   logic [31:0] msg;
   logic        sent_msg_vld;
   logic [1:0]  sent_core_id;
   logic        rcv_msg_vld;
   logic [1:0]  rcv_core_id;
   logic [3:0]  stall;
   logic        release_vld;
   logic [1:0]  release_core_id;
   logic [15:0] min_time;
   logic        min_time_vld;
   logic [2:0]  active_cnt;
   logic        proto_err;

   int compared   = 0;
   int mismatched = 0;

   // Model state (committed at each clock edge) and its next-state copy.
   int   mTime [4];
   int   mLp   [4];
   bit   mActive [4];
   bit   mStalled [4];
   bit   mProto, mRelVld, mMinVld;
   int   mRelId, mMinTime, mActCnt;
   int   nTime [4];
   int   nLp   [4];
   bit   nActive [4];
   bit   nStalled [4];
   bit   nProto, nRelVld, nMinVld;
   int   nRelId, nMinTime, nActCnt;
   logic [3:0] expStall;

   lp_lock_monitor #(
      .NUM_CORE(NUM_CORE), .NUM_LP(NUM_LP), .TIME_WID(TIME_WID), .MSG_WID(MSG_WID)
   ) dut (
      .clk(clk), .reset(reset), .msg(msg),
      .sent_msg_vld(sent_msg_vld), .sent_core_id(sent_core_id),
      .rcv_msg_vld(rcv_msg_vld), .rcv_core_id(rcv_core_id),
      .stall(stall), .release_vld(release_vld), .release_core_id(release_core_id),
      .min_time(min_time), .min_time_vld(min_time_vld),
      .active_cnt(active_cnt), .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for every check in this bench.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic logic [31:0] mkMsg(input int lp, input int t);
      logic [31:0] m;
      m        = '0;
      m[15:0]  = t[15:0];
      m[18:16] = lp[2:0];
      return m;
   endfunction

   // Behavioural model: finish first, then dispatch, on a copy of the table.
   task automatic modelEval(input bit rst, input bit sv, input int sc,
                            input bit rv, input int rc, input logic [31:0] m);
      int lpIn, tIn, lpK, minT, relPick;
      int waitQ [$];
      bit conflict;
      lpIn = int'(m[18:16]);
      tIn  = int'(m[15:0]);
      for (int i = 0; i < 4; i++) begin
         nTime[i] = mTime[i]; nLp[i] = mLp[i];
         nActive[i] = mActive[i]; nStalled[i] = mStalled[i];
      end
      nProto  = mProto;
      nRelVld = 1'b0;
      nRelId  = mRelId;
      // Minimum over the table as it stands before this edge.
      nMinVld  = 1'b0;
      nMinTime = 0;
      for (int i = 0; i < 4; i++) begin
         if (mActive[i] && (!nMinVld || mTime[i] < nMinTime)) begin
            nMinTime = mTime[i];
            nMinVld  = 1'b1;
         end
      end
      if (rv) begin
         if (!nActive[rc]) begin
            nProto = 1'b1;
         end else begin
            lpK = nLp[rc];
            nActive[rc]  = 1'b0;
            nStalled[rc] = 1'b0;
            for (int j = 0; j < 4; j++)
               if (nActive[j] && nStalled[j] && nLp[j] == lpK) waitQ.push_back(j);
            if (waitQ.size() > 0) begin
               minT = 1 << 20;
               foreach (waitQ[q]) if (nTime[waitQ[q]] < minT) minT = nTime[waitQ[q]];
               relPick = -1;
               foreach (waitQ[q]) if (relPick < 0 && nTime[waitQ[q]] == minT) relPick = waitQ[q];
               nStalled[relPick] = 1'b0;
               nRelVld = 1'b1;
               nRelId  = relPick;
            end
         end
      end
      conflict = 1'b0;
      if (sv) begin
         for (int j = 0; j < 4; j++)
            if (j != sc && nActive[j] && nLp[j] == lpIn) conflict = 1'b1;
         if (nActive[sc]) nProto = 1'b1;
         nTime[sc]    = tIn;
         nLp[sc]      = lpIn;
         nActive[sc]  = 1'b1;
         nStalled[sc] = conflict;
      end
      for (int i = 0; i < 4; i++) expStall[i] = mStalled[i];
      if (!rst && conflict) expStall[sc] = 1'b1;
      nActCnt = 0;
      for (int i = 0; i < 4; i++) nActCnt += int'(nActive[i]);
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            nTime[i] = 0; nLp[i] = 0; nActive[i] = 0; nStalled[i] = 0;
         end
         nProto = 0; nRelVld = 0; nRelId = 0; nMinVld = 0; nMinTime = 0; nActCnt = 0;
      end
   endtask

   task automatic modelCommit();
      for (int i = 0; i < 4; i++) begin
         mTime[i] = nTime[i]; mLp[i] = nLp[i];
         mActive[i] = nActive[i]; mStalled[i] = nStalled[i];
      end
      mProto = nProto; mRelVld = nRelVld; mRelId = nRelId;
      mMinVld = nMinVld; mMinTime = nMinTime; mActCnt = nActCnt;
   endtask

   // One clock cycle: drive at the falling edge, check, then clock the model.
   task automatic applyStimulus(input bit rst, input bit sv, input int sc,
                                input bit rv, input int rc, input logic [31:0] m);
      @(negedge clk);
      reset        = rst;
      sent_msg_vld = sv;
      sent_core_id = 2'(sc);
      rcv_msg_vld  = rv;
      rcv_core_id  = 2'(rc);
      msg          = m;
      #1;
      modelEval(rst, sv, sc, rv, rc, m);
      checkOutput("stall", 32'(stall), 32'(expStall));
      checkOutput("release_vld", 32'(release_vld), 32'(mRelVld));
      if (mRelVld) checkOutput("release_core_id", 32'(release_core_id), 32'(mRelId));
      checkOutput("min_time", 32'(min_time), 32'(mMinTime));
      checkOutput("min_time_vld", 32'(min_time_vld), 32'(mMinVld));
      checkOutput("active_cnt", 32'(active_cnt), 32'(mActCnt));
      checkOutput("proto_err", 32'(proto_err), 32'(mProto));
      @(posedge clk);
      modelCommit();
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, '0);
   endtask

   task automatic doReset();
      applyStimulus(1, 0, 0, 0, 0, '0);
   endtask

   initial begin
      bit sv, rv;
      int sc, rc;
      reset = 1'b1; msg = '0; sent_msg_vld = 0; sent_core_id = 0;
      rcv_msg_vld = 0; rcv_core_id = 0;
      for (int i = 0; i < 4; i++) begin
         nTime[i] = 0; nLp[i] = 0; nActive[i] = 0; nStalled[i] = 0;
      end
      nProto = 0; nRelVld = 0; nRelId = 0; nMinVld = 0; nMinTime = 0; nActCnt = 0;
      repeat (2) @(posedge clk);
      modelCommit();
      doReset();
      checkOutput("reset_stall", 32'(stall), 32'd0);
      checkOutput("reset_active_cnt", 32'(active_cnt), 32'd0);

      // LP3 t=10 on core0, then LP3 t=5 on core1 stalls core1.
      applyStimulus(0, 1, 0, 0, 0, mkMsg(3, 10));
      applyStimulus(0, 1, 1, 0, 0, mkMsg(3, 5));
      checkOutput("s1_stall1_send_cycle", 32'(stall[1]), 32'd1);
      checkOutput("s1_stall0_send_cycle", 32'(stall[0]), 32'd0);
      idle();
      checkOutput("s1_stall1_after", 32'(stall[1]), 32'd1);
      idle();
      checkOutput("s1_min_time", 32'(min_time), 32'd5);

      // Three waiters on LP3 with times 30,20,20: tie goes to core2.
      doReset();
      applyStimulus(0, 1, 0, 0, 0, mkMsg(3, 40));
      applyStimulus(0, 1, 1, 0, 0, mkMsg(3, 30));
      applyStimulus(0, 1, 2, 0, 0, mkMsg(3, 20));
      applyStimulus(0, 1, 3, 0, 0, mkMsg(3, 20));
      applyStimulus(0, 0, 0, 1, 0, '0);
      idle();
      checkOutput("s2_release_vld", 32'(release_vld), 32'd1);
      checkOutput("s2_release_id", 32'(release_core_id), 32'd2);
      checkOutput("s2_stall", 32'(stall), 32'b1010);

      // Same-cycle finish and re-dispatch on core0 while core1 waits on LP2.
      doReset();
      applyStimulus(0, 1, 0, 0, 0, mkMsg(2, 7));
      applyStimulus(0, 1, 1, 0, 0, mkMsg(2, 9));
      applyStimulus(0, 1, 0, 1, 0, mkMsg(2, 11));
      checkOutput("s3_stall0_send_cycle", 32'(stall[0]), 32'd1);
      idle();
      checkOutput("s3_release_id", 32'(release_core_id), 32'd1);
      checkOutput("s3_stall", 32'(stall), 32'b0001);
      checkOutput("s3_proto_err", 32'(proto_err), 32'd0);

      // Dispatch to an already active core is sticky until reset.
      doReset();
      applyStimulus(0, 1, 2, 0, 0, mkMsg(1, 1));
      applyStimulus(0, 1, 2, 0, 0, mkMsg(1, 2));
      idle();
      checkOutput("s4_proto_set", 32'(proto_err), 32'd1);
      repeat (3) idle();
      checkOutput("s4_proto_sticky", 32'(proto_err), 32'd1);
      doReset();
      idle();
      checkOutput("s4_proto_cleared", 32'(proto_err), 32'd0);

      // Reset with three active cores (two stalled) drops the waiters.
      applyStimulus(0, 1, 0, 0, 0, mkMsg(5, 3));
      applyStimulus(0, 1, 1, 0, 0, mkMsg(5, 4));
      applyStimulus(0, 1, 2, 0, 0, mkMsg(5, 6));
      applyStimulus(1, 0, 0, 1, 0, '0);
      idle();
      checkOutput("s5_stall", 32'(stall), 32'd0);
      checkOutput("s5_active_cnt", 32'(active_cnt), 32'd0);
      checkOutput("s5_min_vld", 32'(min_time_vld), 32'd0);
      checkOutput("s5_release_vld", 32'(release_vld), 32'd0);

      // Randomized traffic, mostly legal, on a few LPs to force contention.
      for (int seg = 0; seg < 12; seg++) begin
         doReset();
         for (int c = 0; c < 50; c++) begin
            rv = ($urandom_range(0, 1) == 1);
            rc = $urandom_range(0, 3);
            if (rv && !mActive[rc] && $urandom_range(0, 19) != 0) rv = 0;
            sv = ($urandom_range(0, 1) == 1);
            sc = $urandom_range(0, 3);
            if (sv && mActive[sc] && !(rv && rc == sc) && $urandom_range(0, 19) != 0) sv = 0;
            applyStimulus(0, sv, sc, rv, rc,
                          mkMsg($urandom_range(0, 2), $urandom_range(0, 7)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/lp_lock_monitor.md
LP_LOCK_MONITOR -- requirements
Module: lp_lock_monitor

Interface
REQ-001 Parameter NUM_CORE, default 4, core count; power of two, >= 2.
REQ-002 Parameter NUM_LP, default 8, LP count; LP id width NB_LP = clog2(NUM_LP).
REQ-003 Parameter TIME_WID, default 16, timestamp width.
REQ-004 Parameter MSG_WID, default 32, message width; event time is msg[TIME_WID-1:0], LP id is msg[TIME_WID +: NB_LP].
REQ-005 Single clock clk; reset is synchronous and active-high.
REQ-006 Port list, name direction width meaning:
 clk  in  1  clock
 reset  in  1  synchronous active-high reset
 msg  in  MSG_WID  event being dispatched to a core
 sent_msg_vld  in  1  msg dispatched to core sent_core_id this cycle
 sent_core_id  in  clog2(NUM_CORE)  destination core
 rcv_msg_vld  in  1  core rcv_core_id finished its event this cycle
 rcv_core_id  in  clog2(NUM_CORE)  finishing core
 stall  out  NUM_CORE  per-core stall
 release_vld  out  1  one-cycle pulse: a stalled core was released
 release_core_id  out  clog2(NUM_CORE)  released core
 min_time  out  TIME_WID  smallest timestamp among active cores
 min_time_vld  out  1  at least one core active
 active_cnt  out  clog2(NUM_CORE+1)  number of active cores
 proto_err  out  1  sticky protocol-violation flag

Function
REQ-007 Per core, state SHALL hold: time[TIME_WID], lp[NB_LP], active, stalled.
REQ-008 Each cycle, receive is processed first, then send, so send and receive may both be valid in the same cycle, on the same core or on different cores.
REQ-009 Receive from an active core k: active[k]<=0, stalled[k]<=0 at the next edge.
REQ-010 On receive, waiters = active, stalled cores other than k with lp equal to lp[k]; the waiter with smallest time SHALL be released (stalled<=0); ties go to the lowest core index.
REQ-011 On release, release_vld=1 and release_core_id=released core in the cycle after the receive edge; otherwise release_vld=0.
REQ-012 Send to core s: time[s], lp[s] loaded from msg, active[s]<=1.
REQ-013 The send conflicts if any core j != s exists such that active[j], lp[j]==msg LP, and j was not made inactive by a same-cycle receive; on conflict, stalled[s]<=1, else stalled[s]<=0.
REQ-014 A waiter released by a same-cycle receive still counts as active for REQ-013: a new send to that LP stalls.
REQ-015 stall[s] SHALL assert combinationally in the send cycle on conflict: stall = stalled | (send conflict one-hot at s).
REQ-016 Send to a core with active=1 and no same-cycle receive on that core: proto_err<=1; the entry is still overwritten per REQ-012/013.
REQ-017 Receive from an inactive core: proto_err<=1; no state change and no release.
REQ-018 proto_err is sticky until reset.
REQ-019 min_time/min_time_vld SHALL be registered: one-cycle latency from the table state, computed as the minimum time over active cores with a log2(NUM_CORE)-level reduction tree; min_time=0 when min_time_vld=0.
REQ-020 active_cnt SHALL be registered and equal the popcount of active after each edge.
REQ-021 Comparisons are unsigned; no wrap-around handling of timestamps.

Reset
REQ-022 When reset=1 at an edge, all table fields <=0, and stall, release_vld, min_time, min_time_vld, active_cnt and proto_err <=0; the combinational stall term is also forced 0 while reset=1.
REQ-023 Reset mid-operation discards all pending waiters; no release pulses are produced for them.

Verification (NUM_CORE=4, NUM_LP=8, TIME_WID=16)
REQ-024 Send LP3 t=10 to core0, then LP3 t=5 to core1 -> stall[1]=1 in the send cycle and after; stall[0]=0; min_time=5 two cycles after the second send.
REQ-025 Cores 1,2,3 stalled on LP3 with t=30,20,20; receive core0 -> release_vld=1, release_core_id=2 next cycle; stall=4'b1010.
REQ-026 Same cycle: receive core0 (LP2, waiter core1) and send LP2 to core0 -> core1 released, core0 stalled, proto_err=0.
REQ-027 Send to active core2 without receive -> proto_err=1; stays 1 until reset.
REQ-028 Reset asserted with 3 active cores and 2 stalled -> next cycle stall=0, active_cnt=0, min_time_vld=0, no release_vld.
